dsp48_sched: RTL and testbench
==============================

# dsp48_sched

Multi-requester scheduler for one DSP48A1 slice. It takes operand sets (A, B, D, C) from N_REQ requesters over valid/ready handshakes and grants them round-robin, one per cycle, into the slice. It tracks every in-flight operation through the slice pipeline and returns each P result, tagged with its requester ID, through a buffered response port with backpressure. It sits between the request sources and a DSP48A1 instance; the slice itself (pre-add/sub, multiply, post-add, OPERATION parameter) is unchanged.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DSP_LAT, 4: cycles from operands presented on dsp_* to the matching dsp_p being valid; must match the slice instance.
- RSP_DEPTH, 8: response FIFO entries, power of two, ≥ 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a, req_b, req_d  in  N_REQ×18  packed 18-bit operands; requester i occupies bits [18i+17:18i].
- req_c  in  N_REQ×48  packed 48-bit C operands.
- dsp_a, dsp_b, dsp_d  out  18 each  registered operands to the slice.
- dsp_c  out  48  registered C operand to the slice.
- dsp_p  in  48  slice result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  clog2(N_REQ)  requester that issued this result.
- rsp_p  out  48  result.
- busy  out  1  high while any operation is in flight or buffered.

## Operation
- Eligibility: an issue is allowed only when in_flight + fifo_count < RSP_DEPTH. This credit check makes the FIFO impossible to overflow, because the slice cannot be stalled.
- Arbitration: round-robin over the asserted req_valid bits, starting at last_grant+1. req_ready[i] is combinational and depends on req_valid and on the registered pointer and credit state. A handshake is req_valid[i] && req_ready[i]. last_grant updates only on a handshake.
- Issue: on a handshake, dsp_* register the granted operands. In cycles with no handshake, dsp_* register all zeros (bubble).
- Tag pipeline: DSP_LAT+1 stages holding {valid, id}, shifted every cycle. Stage 0 is loaded on a handshake.
- When the last stage is valid, dsp_p is sampled and {id, dsp_p} is pushed into the FIFO.
- FIFO: first-word-fall-through. rsp_* show the head entry. Pop on rsp_valid && rsp_ready. Push and pop in the same cycle are both allowed, full or not.
- Ordering: responses leave in issue order.
- Counters: in_flight counts valid tag stages and goes 0..DSP_LAT+1. Credit uses the registered counts, so a pop frees credit in the next cycle.
- busy = (in_flight != 0) || rsp_valid.

## Timing
- Reset, asynchronous: req_ready=0, dsp_*=0, all tag stages invalid, FIFO empty, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, last_grant=N_REQ-1, so requester 0 wins first.
- Handshake in cycle t:
  - operands appear on dsp_* in cycle t+1;
  - dsp_p is sampled in cycle t+1+DSP_LAT;
  - rsp_valid is high in cycle t+2+DSP_LAT when the FIFO was empty.
  - Default latency is 6 cycles.
- Throughput: one issue per cycle while credit remains.
- rsp_valid, rsp_id and rsp_p hold stable while rsp_ready is low.
- Reset asserted mid-operation discards all in-flight and buffered results. There is no partial output after reset releases.
- A requester that drops req_valid without a handshake loses nothing and causes no pointer update.

## Configuration
- DSP48_SCHED_FIXED_PRIO_EN defined: fixed priority is used, lowest index wins, last_grant is unused, and starvation is possible by design.
- Not defined: round-robin as described above.

## Structure
- Package dsp48_sched_pkg holds:
  - localparams A_W=18, C_W=48, P_W=48;
  - the tag struct {valid, id};
  - the response entry struct {id, p};
  - a round-robin pick function.
- Sub-module dsp48_sched_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.
- Bench: instantiate with a behavioural DSP48A1 model, OPERATION="ADD", latency DSP_LAT.

## Test plan
- Single op: requester 0 sends A=4, B=2, D=3, C=10 at cycle t -> rsp_valid in cycle t+6 with rsp_p=30 and rsp_id=0; busy falls the cycle after the pop.
- Fairness: all 4 requesters held valid, each with distinct operands -> grants 0,1,2,3,0,… on consecutive cycles; results arrive in the same order. One vector is A=6, B=1, D=7, C=12 -> 60.
- Backpressure: rsp_ready=0 with continuous requests -> exactly RSP_DEPTH handshakes, then req_ready=0. Raising rsp_ready resumes issue one cycle after the first pop; no result is lost or duplicated.
- Bubble: requests spaced 3 cycles apart -> dsp_* are zero between issues, and each response arrives exactly 6 cycles after its handshake.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight and 2 buffered -> outputs are at reset values immediately; no rsp_valid after release until a new handshake.
- With DSP48_SCHED_FIXED_PRIO_EN: requesters 0 and 2 held valid -> requester 0 is granted every cycle and requester 2 never.

Source files
------------

// File: rtl/dsp48_sched_pkg.sv
// dsp48_sched_pkg: shared widths, tag/response types and grant pickers for dsp48_sched
package dsp48_sched_pkg;
  localparam int A_W = 18;
  localparam int C_W = 48;
  localparam int P_W = 48;
  localparam int ID_W = 3;
  localparam int MAX_REQ = 8;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } rsp_entry_t;
  // Returns {found, index}; scans from last+1 so the nearest requester after last wins.
  function automatic logic [ID_W:0] rr_pick(input logic [MAX_REQ-1:0] v, input logic [ID_W-1:0] last, input int n);
    logic [ID_W:0] r;
    int j;
    r = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % n;
      if (k <= n && v[j[ID_W-1:0]]) r = {1'b1, j[ID_W-1:0]};
    end
    return r;
  endfunction
  // Returns {found, index}; lowest index wins.
  function automatic logic [ID_W:0] prio_pick(input logic [MAX_REQ-1:0] v, input int n);
    logic [ID_W:0] r;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (k < n && v[ID_W'(k)]) r = {1'b1, ID_W'(k)};
    return r;
  endfunction
endpackage

// File: rtl/dsp48_sched_fifo.sv
// dsp48_sched_fifo: first-word-fall-through FIFO, head shown on dout (zero when empty)
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty, count.
module dsp48_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign empty = r_count == '0;
  assign full = r_count == (AW+1)'(DEPTH);
  assign count = r_count;
  assign w_pop = pop && !empty;
  // A pop frees the slot being written, so push is accepted even when full.
  assign w_push = push && (!full || w_pop);
  assign dout = empty ? '0 : r_mem[r_rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= din;
endmodule

// File: rtl/dsp48_sched.sv
// dsp48_sched: round-robin scheduler feeding one DSP48A1 slice with tagged, buffered results
// Ports: req_valid/req_ready + packed req_a/b/d/c operands in; dsp_a/b/d/c registered to slice,
// dsp_p back; rsp_valid/rsp_ready/rsp_id/rsp_p response; busy while work in flight or buffered.
// Macro DSP48_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module dsp48_sched
  import dsp48_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DSP_LAT = 4,
  parameter int RSP_DEPTH = 8,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*A_W-1:0]   req_b,
  input  logic [N_REQ*A_W-1:0]   req_d,
  input  logic [N_REQ*C_W-1:0]   req_c,
  output logic [A_W-1:0]         dsp_a,
  output logic [A_W-1:0]         dsp_b,
  output logic [A_W-1:0]         dsp_d,
  output logic [C_W-1:0]         dsp_c,
  input  logic [P_W-1:0]         dsp_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IW-1:0]          rsp_id,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  tag_t r_tag [DSP_LAT+1];
  logic [7:0] r_in_flight;
  logic [CW-1:0] w_count;
  logic w_full, w_empty, w_credit, w_hs;
  logic [ID_W:0] w_pick;
  logic [ID_W-1:0] w_idx;
  rsp_entry_t w_head, w_push_entry;
  logic w_unused;
`ifdef DSP48_SCHED_FIXED_PRIO_EN
  assign w_pick = prio_pick(MAX_REQ'(req_valid), N_REQ);
`else
  logic [ID_W-1:0] r_last_grant;
  assign w_pick = rr_pick(MAX_REQ'(req_valid), r_last_grant, N_REQ);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_grant <= ID_W'(N_REQ - 1);
    else if (w_hs) r_last_grant <= w_idx;
`endif
  // The slice cannot stall, so every issue must already own a FIFO slot.
  assign w_credit = 32'(r_in_flight) + 32'(w_count) < 32'(RSP_DEPTH);
  assign w_idx = w_pick[ID_W-1:0];
  assign req_ready = (rst_n && w_credit && w_pick[ID_W]) ? N_REQ'(1) << w_idx : '0;
  assign w_hs = |(req_valid & req_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dsp_a <= '0;
      dsp_b <= '0;
      dsp_d <= '0;
      dsp_c <= '0;
      r_in_flight <= '0;
      for (int k = 0; k <= DSP_LAT; k++) r_tag[k] <= '0;
    end else begin
      dsp_a <= w_hs ? req_a[w_idx*A_W +: A_W] : '0;
      dsp_b <= w_hs ? req_b[w_idx*A_W +: A_W] : '0;
      dsp_d <= w_hs ? req_d[w_idx*A_W +: A_W] : '0;
      dsp_c <= w_hs ? req_c[w_idx*C_W +: C_W] : '0;
      r_tag[0] <= '{valid: w_hs, id: w_hs ? w_idx : '0};
      for (int k = 1; k <= DSP_LAT; k++) r_tag[k] <= r_tag[k-1];
      r_in_flight <= r_in_flight + 8'(w_hs) - 8'(r_tag[DSP_LAT].valid);
    end
  assign w_push_entry = '{id: r_tag[DSP_LAT].id, p: dsp_p};
  dsp48_sched_fifo #(
    .WIDTH($bits(rsp_entry_t)),
    .DEPTH(RSP_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(r_tag[DSP_LAT].valid),
    .pop(rsp_valid && rsp_ready),
    .din(w_push_entry),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty),
    .count(w_count)
  );
  assign rsp_valid = !w_empty;
  assign rsp_id = w_head.id[IW-1:0];
  assign rsp_p = w_head.p;
  assign busy = (r_in_flight != '0) || rsp_valid;
  // Full is implied by the credit check; upper id bits are zero for small N_REQ.
  assign w_unused = ^{w_full, w_head.id >> IW};
endmodule

// File: tb/tb_dsp48_sched.sv
// tb_dsp48_sched: randomized and directed checks of dsp48_sched against a transaction-level model
`timescale 1ns/1ps
module tb_dsp48_sched;
  localparam int N = 4, LAT = 4, DEPTH = 8, IW = 2;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*18-1:0] req_a = '0, req_b = '0, req_d = '0;
  logic [N*48-1:0] req_c = '0;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic rsp_valid, rsp_ready = 0, busy;
  logic [IW-1:0] rsp_id;
  logic [47:0] rsp_p;
  always #5 clk = ~clk;
  dsp48_sched #(.N_REQ(N), .DSP_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );
  // Behavioural DSP48A1, OPERATION="ADD": P = (D + B) * A + C, LAT cycles after dsp_* inputs.
  function automatic logic [47:0] mac(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d, input logic [47:0] c);
    logic signed [17:0] pre;
    logic signed [35:0] m;
    pre = d + b;
    m = pre * $signed(a);
    return {{12{m[35]}}, m} + c;
  endfunction
  logic [47:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mac(dsp_a, dsp_b, dsp_d, dsp_c);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dsp_p = pipe[LAT-1];
  // Model: every issued op stays in q until popped; it becomes visible 2+LAT cycles after issue.
  typedef struct { int id; logic [47:0] p; longint avail; } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0, last = N - 1, hs_count = 0;
  longint cyc = 0, last_hs_cyc = 0;
  logic prev_hs = 0, chk60 = 0;
  logic [17:0] pa = '0, pb = '0, pd = '0;
  logic [47:0] pc = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v);
`ifdef DSP48_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction
  task automatic cycle();
    int g;
    logic exp_v;
    logic [N-1:0] exp_r;
    #1;
    if (!rst_n) begin
      q.delete();
      last = N - 1;
      prev_hs = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dsp", {dsp_a, dsp_b, dsp_d} | dsp_c, 0);
    end else begin
      exp_v = q.size() > 0 && q[0].avail <= cyc;
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_p", rsp_p, q[0].p);
        if (chk60 && q[0].id == 1) chk("fair_60", rsp_p, 60);
      end
      chk("busy", busy, q.size() != 0);
      chk("dsp_a", dsp_a, prev_hs ? pa : 18'd0);
      chk("dsp_b", dsp_b, prev_hs ? pb : 18'd0);
      chk("dsp_d", dsp_d, prev_hs ? pd : 18'd0);
      chk("dsp_c", dsp_c, prev_hs ? pc : 48'd0);
      g = (q.size() < DEPTH) ? pick(req_valid) : -1;
      exp_r = g < 0 ? '0 : N'(1) << g;
      chk("req_ready", req_ready, exp_r);
      if (exp_v && rsp_ready) void'(q.pop_front());
      prev_hs = g >= 0;
      if (g >= 0) begin
        pa = req_a[g*18 +: 18];
        pb = req_b[g*18 +: 18];
        pd = req_d[g*18 +: 18];
        pc = req_c[g*48 +: 48];
        q.push_back('{g, mac(pa, pb, pd, pc), cyc + 2 + LAT});
        last = g;
        hs_count++;
        last_hs_cyc = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*18 +: 18] = 18'($urandom);
      req_b[i*18 +: 18] = 18'($urandom);
      req_d[i*18 +: 18] = 18'($urandom);
      req_c[i*48 +: 48] = {16'($urandom), 32'($urandom)};
    end
    if (chk60) {req_a[35:18], req_b[35:18], req_d[35:18], req_c[95:48]} = {18'd6, 18'd1, 18'd7, 48'd12};
  endtask
  task automatic run(input int n, input logic [N-1:0] v, input logic rnd);
    for (int i = 0; i < n; i++) begin
      req_valid = v;
      if (rnd) rnd_ops();
      cycle();
    end
  endtask
  initial begin
    int hs0;
    logic found;
    longint hs_cyc;
    @(negedge clk);
    run(2, '0, 0);
    rst_n = 1;
    rsp_ready = 1;
    run(1, '0, 0);
    // single op: (3 + 2) * 4 + 10 = 30, six cycles after the handshake
    {req_a[17:0], req_b[17:0], req_d[17:0], req_c[47:0]} = {18'd4, 18'd2, 18'd3, 48'd10};
    run(1, 4'b0001, 0);
    hs_cyc = last_hs_cyc;
    req_valid = '0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rsp_valid) begin
        found = 1;
        chk("single_latency", 64'(cyc - hs_cyc), 6);
        chk("single_p", rsp_p, 30);
        chk("single_id", rsp_id, 0);
        chk("single_busy_hi", busy, 1);
      end
      cycle();
    end
    chk("single_seen", found, 1);
    chk("single_busy_fall", busy, 0);
    // fairness with requester 1 fixed at (7 + 1) * 6 + 12 = 60
    chk60 = 1;
    run(12, 4'hF, 1);
    run(10, '0, 0);
    chk60 = 0;
    // backpressure: credit admits exactly DEPTH ops
    rsp_ready = 0;
    hs0 = hs_count;
    run(16, 4'hF, 1);
    chk("bp_handshakes", hs_count - hs0, DEPTH);
    rsp_ready = 1;
    run(6, 4'hF, 1);
    run(20, '0, 0);
    // bubbles between spaced issues
    for (int i = 0; i < 6; i++) begin
      run(1, N'(1) << $urandom_range(N - 1), 1);
      run(2, '0, 0);
    end
    run(10, '0, 0);
    // random traffic and random backpressure
    for (int i = 0; i < 300; i++) begin
      rsp_ready = ($urandom % 4) != 0;
      run(1, N'($urandom), 1);
    end
    rsp_ready = 1;
    run(30, '0, 0);
    // reset with 2 buffered and 3 in flight
    rsp_ready = 0;
    run(5, 4'b0001, 1);
    run(2, '0, 0);
    rst_n = 0;
    run(2, '0, 0);
    rst_n = 1;
    rsp_ready = 1;
    run(10, '0, 0);
    run(1, 4'b0100, 1);
    run(10, '0, 0);
    // requesters 0 and 2 contending
    run(12, 4'b0101, 1);
    run(12, '0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
